// File: rtl/tmfir_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate stepped over N_TAPS coefficients per sample.
// Owns the delay line, coefficient bank, accumulator and output formatting with overflow flag.
module tmfir_sequencer #(
    parameter int unsigned N_TAPS = 8,
    parameter int unsigned WI_X   = 2,
    parameter int unsigned WF_X   = 6,
    parameter int unsigned WI_C   = 2,
    parameter int unsigned WF_C   = 6,
    parameter int unsigned WI_A   = 8,
    parameter int unsigned WI_O   = 4,
    parameter int unsigned WF_O   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WI_X+WF_X-1:0]          in_data,
    input  logic                          coef_we,
    input  logic [$clog2(N_TAPS)-1:0]     coef_addr,
    input  logic [WI_C+WF_C-1:0]          coef_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WI_O+WF_O-1:0]          out_data,
    output logic                          out_ovf,
    output logic                          busy
);
    localparam int unsigned AW  = $clog2(N_TAPS);
    localparam int unsigned WX  = WI_X + WF_X;
    localparam int unsigned WC  = WI_C + WF_C;
    localparam int unsigned WP  = WX + WC;
    localparam int unsigned WFA = WF_X + WF_C;
    localparam int unsigned WA  = WI_A + WFA;
    localparam int unsigned WO  = WI_O + WF_O;
    localparam int unsigned OB  = WFA + WI_O - 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t               state;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        k;
    logic signed [WA-1:0] acc;
    logic signed [WX-1:0] delay [N_TAPS];
    logic signed [WC-1:0] coef  [N_TAPS];

    logic signed [WX-1:0] delay_rd;
    logic signed [WC-1:0] coef_rd;
    logic signed [WP-1:0] prod;
    logic signed [WA-1:0] acc_next;
    logic [WA-OB-1:0]     int_top;

    // One MAC term per cycle; newest sample pairs with coef[0]
    always_comb begin
        coef_rd  = coef[k];
        delay_rd = delay[wr_ptr - k];
        prod     = WP'(coef_rd) * WP'(delay_rd);
        acc_next = acc + WA'(prod);
        int_top  = acc_next[WA-1:OB];
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            for (int i = 0; i < int'(N_TAPS); i++) begin
                delay[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we) coef[coef_addr] <= coef_data;
                    if (in_valid) begin
                        delay[wr_ptr] <= in_data;
                        k             <= '0;
                        acc           <= '0;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + AW'(1);
                    if (k == AW'(N_TAPS - 1)) begin
                        // Floor-truncate fraction, wrap integer; flag if dropped integer bits were not sign copies
                        out_data  <= acc_next[WFA-WF_O +: WO];
                        out_ovf   <= !((&int_top) || (~|int_top));
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        wr_ptr    <= wr_ptr + AW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tmfir_sequencer.sv
// Self-checking bench for tmfir_sequencer: directed tables plus random traffic
// against an arithmetic convolution model over the accepted-sample history.
module tb_tmfir_sequencer;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_ovf;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int coef_m [N];
    int hist [$];

    tmfir_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // y = sum coef[k] * x[n-k] in Q.12; output = floor(y/16) mod 2^12; ovf if floor(y/4096) outside [-8,7]
    task automatic model(output logic [31:0] d, output logic [31:0] o);
        int y;
        int yi;
        y = 0;
        for (int i = 0; i < hist.size() && i < N; i++) y += coef_m[i] * hist[i];
        d  = 32'((y >>> 4) & 32'hFFF);
        yi = y >>> 12;
        o  = 32'((yi < -8 || yi > 7) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        out_ready = 1'b0;
        hist.delete();
        for (int i = 0; i < N; i++) coef_m[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic write_coef(input int a, input logic [7:0] v);
        check("coef_wr_idle", 32'(in_ready), 32'd1);
        coef_we = 1'b1; coef_addr = 3'(a); coef_data = v;
        step();
        coef_we = 1'b0;
        coef_m[a] = sx8(v);
    endtask

    // Offer one sample, check latency/result, optionally stall and scribble coefs, then hand off
    task automatic run_sample(input logic [7:0] x, input int stall, input bit same_wr,
                              input int wa, input logic [7:0] wv, input bit junk);
        logic [31:0] ed, eo;
        int lat;
        lat = 0;
        while (!in_ready && lat < 40) begin step(); lat++; end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = x;
        if (same_wr) begin coef_we = 1'b1; coef_addr = 3'(wa); coef_data = wv; end
        step();
        in_valid = 1'b0; coef_we = 1'b0;
        if (same_wr) coef_m[wa] = sx8(wv);
        hist.push_front(sx8(x));
        if (hist.size() > N) void'(hist.pop_back());
        model(ed, eo);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (junk) begin
                coef_we = 1'b1; coef_addr = 3'($urandom_range(0, 7)); coef_data = 8'($urandom);
            end
            step();
            lat++;
        end
        coef_we = 1'b0;
        check("latency", 32'(lat), 32'(N));
        check("out_data", 32'(out_data), ed);
        check("out_ovf", 32'(out_ovf), eo);
        check("busy_out", 32'(busy), 32'd1);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
            if (junk) begin
                coef_we = 1'b1; coef_addr = 3'($urandom_range(0, 7)); coef_data = 8'($urandom);
            end
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), ed);
            check("stall_ovf", 32'(out_ovf), eo);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; coef_we = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after_hs_valid", 32'(out_valid), 32'd0);
        check("after_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ed, eo;
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Impulse response: expect 32*(k+1)
        for (int i = 0; i < N; i++) write_coef(i, 8'(8 * (i + 1)));
        for (int i = 0; i < N; i++) begin
            run_sample(i == 0 ? 8'h40 : 8'h00, 0, 1'b0, 0, 8'h00, 1'b0);
            check("impulse_const", 32'(out_data), 32'(32 * (i + 1)));
        end

        // Step with wrap/overflow on the eighth output
        do_reset();
        for (int i = 0; i < N; i++) write_coef(i, 8'h40);
        for (int i = 0; i < N; i++) run_sample(8'h40, 0, 1'b0, 0, 8'h00, 1'b0);
        check("step_last_data", 32'(out_data), 32'h800);
        check("step_last_ovf", 32'(out_ovf), 32'd1);

        // Sign and floor truncation
        do_reset();
        write_coef(0, 8'h01);
        run_sample(8'h01, 0, 1'b0, 0, 8'h00, 1'b0);
        check("trunc_pos", 32'(out_data), 32'h000);
        run_sample(8'hFF, 0, 1'b0, 0, 8'h00, 1'b0);
        check("trunc_neg", 32'(out_data), 32'hFFF);
        write_coef(0, 8'h80);
        run_sample(8'h80, 0, 1'b0, 0, 8'h00, 1'b0);
        check("neg_neg", 32'(out_data), 32'h400);
        check("neg_neg_ovf", 32'(out_ovf), 32'd0);

        // Backpressure with ignored input pulses
        run_sample(8'h33, 20, 1'b0, 0, 8'h00, 1'b0);
        run_sample(8'hC5, 0, 1'b0, 0, 8'h00, 1'b0);

        // Config lockout and same-cycle write+accept
        do_reset();
        for (int i = 0; i < N; i++) write_coef(i, 8'(8 * (i + 1)));
        run_sample(8'h40, 3, 1'b0, 0, 8'h00, 1'b1);
        for (int i = 1; i < N; i++) run_sample(8'h00, 1, 1'b0, 0, 8'h00, 1'b1);
        run_sample(8'h40, 0, 1'b1, 0, 8'hE0, 1'b0);
        check("same_cycle_wr", 32'(out_data), 32'hF80);

        // Reset mid-MAC discards the in-flight sample and clears coefficients
        in_valid = 1'b1; in_data = 8'h40;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hist.delete();
        for (int i = 0; i < N; i++) coef_m[i] = 0;
        step();
        run_sample(8'h40, 0, 1'b0, 0, 8'h00, 1'b0);
        check("midrst_zero", 32'(out_data), 32'h000);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(0, 7)), 8'($urandom));
            run_sample(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        model(ed, eo);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
